// File: rtl/memory_access.sv
// ----------------------------------------------------------------------------
// memory_access
//
// Memory-access stage of the LC-3 datapath. Takes an effective address and a
// load/store opcode (LD, ST, LDI, STI) and runs the data-memory transaction
// over a request/ready port. The indirect forms first read a pointer, then
// access the word it points to. Load results and their N/Z/P condition code
// go to writeback, and completion is flagged with a one-cycle DONE pulse.
//
// Ports:
//   CLK, RESET             clock; asynchronous active-high reset
//   START, OP, EA,         operation request, sampled only while idle
//   STORE_DATA
//   MEM_REQ, MEM_WE,       memory request port; all four are registered, so
//   MEM_ADDR, MEM_WDATA    they stay stable across wait cycles
//   MEM_RDATA, MEM_READY   memory response; a transfer completes on
//                          MEM_REQ & MEM_READY
//   BUSY, DONE             status, decoded from the state register
//   LOAD_DATA, NZP         last loaded word and its condition code
// ----------------------------------------------------------------------------
module memory_access (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [1:0]  OP,
    input  logic [15:0] EA,
    input  logic [15:0] STORE_DATA,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [15:0] MEM_ADDR,
    output logic [15:0] MEM_WDATA,
    input  logic [15:0] MEM_RDATA,
    input  logic        MEM_READY,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] LOAD_DATA,
    output logic [2:0]  NZP
);

    typedef enum logic [1:0] {
        OP_LD  = 2'b00,
        OP_ST  = 2'b01,
        OP_LDI = 2'b10,
        OP_STI = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ACC1 = 2'b01,
        S_ACC2 = 2'b10,
        S_FIN  = 2'b11
    } state_t;

    state_t      state_q,  state_d;
    op_t         op_q,     op_d;
    logic [15:0] sdata_q,  sdata_d;
    logic        req_q,    req_d;
    logic        we_q,     we_d;
    logic [15:0] addr_q,   addr_d;
    logic [15:0] wdata_q,  wdata_d;
    logic [15:0] load_q,   load_d;
    logic [2:0]  nzp_q,    nzp_d;

    // Condition code of a loaded word; always exactly one bit set.
    function automatic logic [2:0] calc_nzp(input logic [15:0] value);
        if (value[15])
            return 3'b100;
        else if (value == 16'h0000)
            return 3'b010;
        else
            return 3'b001;
    endfunction

    always_comb begin
        // NOTE: every next-state value defaults to its current value first,
        // so no path through the case statement can leave one unassigned and
        // infer a latch.
        state_d = state_q;
        op_d    = op_q;
        sdata_d = sdata_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        nzp_d   = nzp_q;

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    op_d    = op_t'(OP);
                    sdata_d = STORE_DATA;
                    addr_d  = EA;
                    we_d    = (op_t'(OP) == OP_ST);
                    // Write data is only replaced for a write; loads leave it alone.
                    if (op_t'(OP) == OP_ST)
                        wdata_d = STORE_DATA;
                    req_d   = 1'b1;
                    state_d = S_ACC1;
                end
            end

            S_ACC1: begin
                if (MEM_READY) begin
                    unique case (op_q)
                        OP_LD: begin
                            load_d  = MEM_RDATA;
                            nzp_d   = calc_nzp(MEM_RDATA);
                            req_d   = 1'b0;
                            we_d    = 1'b0;
                            state_d = S_FIN;
                        end
                        OP_ST: begin
                            req_d   = 1'b0;
                            we_d    = 1'b0;
                            state_d = S_FIN;
                        end
                        OP_LDI, OP_STI: begin
                            // Pointer read done: retarget the still-active
                            // request at the pointed-to word without dropping REQ.
                            addr_d  = MEM_RDATA;
                            we_d    = (op_q == OP_STI);
                            if (op_q == OP_STI)
                                wdata_d = sdata_q;
                            state_d = S_ACC2;
                        end
                        default: ;
                    endcase
                end
            end

            S_ACC2: begin
                if (MEM_READY) begin
                    if (op_q == OP_LDI) begin
                        load_d = MEM_RDATA;
                        nzp_d  = calc_nzp(MEM_RDATA);
                    end
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = S_FIN;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above, independent of statement order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            op_q    <= OP_LD;
            sdata_q <= 16'h0000;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            load_q  <= 16'h0000;
            nzp_q   <= 3'b010;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sdata_q <= sdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            nzp_q   <= nzp_d;
        end
    end

    assign MEM_REQ   = req_q;
    assign MEM_WE    = we_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = wdata_q;
    assign LOAD_DATA = load_q;
    assign NZP       = nzp_q;
    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = (state_q == S_FIN);

endmodule

// File: tb/tb_memory_access.sv
// ----------------------------------------------------------------------------
// tb_memory_access
//
// Directed testbench for memory_access. A small fixed memory image answers
// reads combinationally from MEM_ADDR; the bench drives MEM_READY to insert
// wait states. Inputs change on the falling edge or just after the rising
// edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_memory_access;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic [1:0]  OP = 2'b00;
    logic [15:0] EA = 16'h0000;
    logic [15:0] STORE_DATA = 16'h0000;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [15:0] MEM_ADDR;
    logic [15:0] MEM_WDATA;
    logic [15:0] MEM_RDATA;
    logic        MEM_READY = 1'b1;
    logic        BUSY;
    logic        DONE;
    logic [15:0] LOAD_DATA;
    logic [2:0]  NZP;

    int n_checks = 0;
    int n_fail   = 0;

    // Writes observed on the memory port.
    int          wr_count = 0;
    logic [15:0] last_wr_addr = 16'h0000;
    logic [15:0] last_wr_data = 16'h0000;

    memory_access dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .OP         (OP),
        .EA         (EA),
        .STORE_DATA (STORE_DATA),
        .MEM_REQ    (MEM_REQ),
        .MEM_WE     (MEM_WE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_WDATA  (MEM_WDATA),
        .MEM_RDATA  (MEM_RDATA),
        .MEM_READY  (MEM_READY),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .LOAD_DATA  (LOAD_DATA),
        .NZP        (NZP)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] mem_read(input logic [15:0] addr);
        case (addr)
            16'h3010: return 16'h8001;
            16'h3000: return 16'h5000;
            16'h5000: return 16'h0000;
            16'h3002: return 16'hFFFF;
            16'h6000: return 16'h0042;
            default:  return 16'hA5A5;
        endcase
    endfunction

    always_comb MEM_RDATA = mem_read(MEM_ADDR);

    always @(posedge CLK) begin
        if (!RESET && MEM_REQ === 1'b1 && MEM_READY && MEM_WE === 1'b1) begin
            wr_count     <= wr_count + 1;
            last_wr_addr <= MEM_ADDR;
            last_wr_data <= MEM_WDATA;
        end
    end

    // Present one operation so that START is sampled at the next rising edge
    // (edge 0), then scramble the inputs to show they are not re-sampled.
    task automatic issue(input logic [1:0] op, input logic [15:0] ea, input logic [15:0] sd);
        @(negedge CLK);
        START      = 1'b1;
        OP         = op;
        EA         = ea;
        STORE_DATA = sd;
        @(posedge CLK);
        #1;
        START      = 1'b0;
        OP         = ~op;
        EA         = 16'hDEAD;
        STORE_DATA = 16'hC0DE;
    endtask

    task automatic test_reset;
        #3 RESET = 1'b1;
        #1;
        n_checks++;
        if ({MEM_REQ, MEM_WE, BUSY, DONE} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got req/we/busy/done=%b want 0000", {MEM_REQ, MEM_WE, BUSY, DONE});
        end
        n_checks++;
        if ({MEM_ADDR, MEM_WDATA, LOAD_DATA} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h wdata=%h load=%h want all 0000", MEM_ADDR, MEM_WDATA, LOAD_DATA);
        end
        n_checks++;
        if (NZP !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_nzp: got %b want 010", NZP);
        end
        START = 1'b1;
        OP    = 2'b00;
        EA    = 16'h3010;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (MEM_REQ !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_start: got req=%b busy=%b want 0 0", MEM_REQ, BUSY);
        end
        START = 1'b0;
        RESET = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (MEM_REQ !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got req=%b busy=%b want 0 0", MEM_REQ, BUSY);
        end
    endtask

    task automatic test_ld;
        MEM_READY = 1'b1;
        issue(2'b00, 16'h3010, 16'h0000);
        @(negedge CLK);  // cycle 1
        n_checks++;
        if ({MEM_REQ, MEM_WE, BUSY, DONE} !== 4'b1010 || MEM_ADDR !== 16'h3010) begin
            n_fail++;
            $display("FAIL ld_cycle1: got req/we/busy/done=%b addr=%h want 1010 3010",
                     {MEM_REQ, MEM_WE, BUSY, DONE}, MEM_ADDR);
        end
        @(negedge CLK);  // cycle 2
        n_checks++;
        if (DONE !== 1'b1 || MEM_REQ !== 1'b0 || LOAD_DATA !== 16'h8001 || NZP !== 3'b100) begin
            n_fail++;
            $display("FAIL ld_done: got done=%b req=%b load=%h nzp=%b want 1 0 8001 100",
                     DONE, MEM_REQ, LOAD_DATA, NZP);
        end
        @(negedge CLK);  // cycle 3
        n_checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_idle_after: got done=%b busy=%b want 0 0", DONE, BUSY);
        end
    endtask

    task automatic test_st_wait;
        int wr_before;
        wr_before = wr_count;
        MEM_READY = 1'b0;
        issue(2'b01, 16'h4000, 16'hBEEF);
        for (int i = 1; i <= 3; i++) begin
            @(negedge CLK);
            n_checks++;
            if ({MEM_REQ, MEM_WE, DONE} !== 3'b110 || MEM_ADDR !== 16'h4000 || MEM_WDATA !== 16'hBEEF) begin
                n_fail++;
                $display("FAIL st_wait_cycle%0d: got req/we/done=%b addr=%h wdata=%h want 110 4000 beef",
                         i, {MEM_REQ, MEM_WE, DONE}, MEM_ADDR, MEM_WDATA);
            end
            if (i == 3) MEM_READY = 1'b1;
        end
        @(negedge CLK);  // cycle 4
        n_checks++;
        if (DONE !== 1'b1 || MEM_REQ !== 1'b0 || MEM_WE !== 1'b0) begin
            n_fail++;
            $display("FAIL st_done: got done=%b req=%b we=%b want 1 0 0", DONE, MEM_REQ, MEM_WE);
        end
        n_checks++;
        if (LOAD_DATA !== 16'h8001 || NZP !== 3'b100) begin
            n_fail++;
            $display("FAIL st_load_kept: got load=%h nzp=%b want 8001 100", LOAD_DATA, NZP);
        end
        n_checks++;
        if (wr_count != wr_before + 1 || last_wr_addr !== 16'h4000 || last_wr_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL st_write_log: got count=%0d addr=%h data=%h want %0d 4000 beef",
                     wr_count, last_wr_addr, last_wr_data, wr_before + 1);
        end
    endtask

    task automatic test_ldi;
        MEM_READY = 1'b1;
        issue(2'b10, 16'h3000, 16'h0000);
        @(negedge CLK);  // cycle 1
        n_checks++;
        if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== 16'h3000) begin
            n_fail++;
            $display("FAIL ldi_ptr_read: got req=%b we=%b addr=%h want 1 0 3000", MEM_REQ, MEM_WE, MEM_ADDR);
        end
        @(negedge CLK);  // cycle 2
        n_checks++;
        if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== 16'h5000 || DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL ldi_data_read: got req=%b we=%b addr=%h done=%b want 1 0 5000 0",
                     MEM_REQ, MEM_WE, MEM_ADDR, DONE);
        end
        @(negedge CLK);  // cycle 3
        n_checks++;
        if (DONE !== 1'b1 || MEM_REQ !== 1'b0 || LOAD_DATA !== 16'h0000 || NZP !== 3'b010) begin
            n_fail++;
            $display("FAIL ldi_done: got done=%b req=%b load=%h nzp=%b want 1 0 0000 010",
                     DONE, MEM_REQ, LOAD_DATA, NZP);
        end
    endtask

    task automatic test_sti;
        MEM_READY = 1'b1;
        issue(2'b11, 16'h3002, 16'h1234);
        @(negedge CLK);  // cycle 1
        n_checks++;
        if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== 16'h3002) begin
            n_fail++;
            $display("FAIL sti_ptr_read: got req=%b we=%b addr=%h want 1 0 3002", MEM_REQ, MEM_WE, MEM_ADDR);
        end
        @(negedge CLK);  // cycle 2
        n_checks++;
        if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b1 || MEM_ADDR !== 16'hFFFF || MEM_WDATA !== 16'h1234) begin
            n_fail++;
            $display("FAIL sti_write: got req=%b we=%b addr=%h wdata=%h want 1 1 ffff 1234",
                     MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA);
        end
        @(negedge CLK);  // cycle 3
        n_checks++;
        if (DONE !== 1'b1 || MEM_WE !== 1'b0 || LOAD_DATA !== 16'h0000 || NZP !== 3'b010) begin
            n_fail++;
            $display("FAIL sti_done: got done=%b we=%b load=%h nzp=%b want 1 0 0000 010",
                     DONE, MEM_WE, LOAD_DATA, NZP);
        end
    endtask

    task automatic test_abort_and_ignore;
        bit seen_done;
        MEM_READY = 1'b0;
        issue(2'b10, 16'h3000, 16'h0000);
        @(negedge CLK);  // cycle 1, waiting in ACC1
        START = 1'b1;    // must be ignored in ACC1
        OP    = 2'b01;
        EA    = 16'h1111;
        @(negedge CLK);
        START = 1'b0;
        n_checks++;
        if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== 16'h3000) begin
            n_fail++;
            $display("FAIL ignore_start_acc1: got req=%b we=%b addr=%h want 1 0 3000", MEM_REQ, MEM_WE, MEM_ADDR);
        end
        MEM_READY = 1'b1;
        @(negedge CLK);  // now in ACC2
        MEM_READY = 1'b0;
        n_checks++;
        if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== 16'h5000) begin
            n_fail++;
            $display("FAIL abort_in_acc2: got req=%b we=%b addr=%h want 1 0 5000", MEM_REQ, MEM_WE, MEM_ADDR);
        end
        RESET = 1'b1;
        #1;
        n_checks++;
        if ({MEM_REQ, MEM_WE, BUSY, DONE} !== 4'b0000 || MEM_ADDR !== 16'h0000 || NZP !== 3'b010) begin
            n_fail++;
            $display("FAIL abort_reset: got req/we/busy/done=%b addr=%h nzp=%b want 0000 0000 010",
                     {MEM_REQ, MEM_WE, BUSY, DONE}, MEM_ADDR, NZP);
        end
        MEM_READY = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (DONE !== 1'b0 || MEM_REQ !== 1'b0) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done) begin
            n_fail++;
            $display("FAIL abort_no_done: got activity after abort want none");
        end
        issue(2'b00, 16'h6000, 16'h0000);
        @(negedge CLK);
        n_checks++;
        if (MEM_REQ !== 1'b1 || MEM_ADDR !== 16'h6000) begin
            n_fail++;
            $display("FAIL fresh_ld_req: got req=%b addr=%h want 1 6000", MEM_REQ, MEM_ADDR);
        end
        @(negedge CLK);
        n_checks++;
        if (DONE !== 1'b1 || LOAD_DATA !== 16'h0042 || NZP !== 3'b001) begin
            n_fail++;
            $display("FAIL fresh_ld_done: got done=%b load=%h nzp=%b want 1 0042 001", DONE, LOAD_DATA, NZP);
        end
    endtask

    initial begin
        test_reset();
        test_ld();
        test_st_wait();
        test_ldi();
        test_sti();
        test_abort_and_ignore();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
